udp_deframer: RTL and testbench

Strips the 8-byte UDP header from the IPv4 payload stream produced by `ip_deframer` and passes the UDP payload downstream on a 4-byte AXI-Stream. It sits directly after the IP deframer in the receive path. It drops frames that are not UDP, frames whose UDP length is inconsistent, and runt frames. Header fields are presented as sideband outputs that stay stable for the whole output frame.

---
 rtl/udp_deframer.sv | 165 ++++++++++++++++
 tb/tb_udp_deframer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_deframer.sv
// UDP deframer: strips the 8-byte UDP header from an IPv4 payload stream and
// forwards the datagram payload. Optional destination-port filter: UDP_DEFRAMER_PORT_FILTER_EN.
module udp_deframer #(
  parameter logic [15:0] LISTEN_PORT = 16'd0
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic [31:0] axis_i_tdata,
  input  logic        axis_i_tvalid,
  input  logic        axis_i_tlast,
  output logic        axis_i_tready,
  input  logic [15:0] axis_i_length,
  input  logic [7:0]  axis_i_protocol,
  input  logic [31:0] axis_i_src_ip,
  input  logic [31:0] axis_i_dst_ip,
  output logic [31:0] axis_o_tdata,
  output logic        axis_o_tvalid,
  output logic        axis_o_tlast,
  input  logic        axis_o_tready,
  output logic [15:0] axis_o_length,
  output logic [15:0] axis_o_src_port,
  output logic [15:0] axis_o_dst_port,
  output logic [31:0] axis_o_src_ip,
  output logic [31:0] axis_o_dst_ip,
  output logic        drop
);

  localparam int AXIS_BYTES = 4;
  localparam logic [7:0]  PROTO_UDP   = 8'd17;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  typedef logic [AXIS_BYTES*8-1:0] word_t;
  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} state_t;

  state_t state, state_nxt;
  logic   drop_nxt;
  logic   drop_armed, drop_armed_nxt;
  logic   load_hdr0, load_len;
  logic   in_hs;
  logic   port_reject;
  logic   len_bad;
  word_t  in_word;
  logic [15:0] hdr_src_port, hdr_dst_port, hdr_udp_len;

  assign in_word = axis_i_tdata;

  // Header fields arrive in network byte order, byte 0 in the low lane.
  assign hdr_src_port = {in_word[7:0],   in_word[15:8]};
  assign hdr_dst_port = {in_word[23:16], in_word[31:24]};
  assign hdr_udp_len  = {in_word[7:0],   in_word[15:8]};

  assign len_bad = (hdr_udp_len < UDP_HDR_LEN) || (hdr_udp_len > axis_i_length);
  assign in_hs   = axis_i_tvalid && axis_i_tready;

`ifdef UDP_DEFRAMER_PORT_FILTER_EN
  assign port_reject = (hdr_dst_port != LISTEN_PORT);
`else
  logic unused_listen_port;
  assign unused_listen_port = ^LISTEN_PORT;
  assign port_reject        = 1'b0;
`endif

  assign axis_o_tdata = in_word;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt      = state;
    drop_nxt       = 1'b0;
    drop_armed_nxt = drop_armed;
    load_hdr0      = 1'b0;
    load_len       = 1'b0;
    axis_i_tready  = 1'b1;
    axis_o_tvalid  = 1'b0;
    axis_o_tlast   = 1'b0;

    case (state)
      HDR0: begin
        if (in_hs) begin
          load_hdr0 = 1'b1;
          if (axis_i_tlast) begin
            drop_nxt = 1'b1;
          end else if ((axis_i_protocol != PROTO_UDP) || port_reject) begin
            state_nxt      = DROP;
            drop_armed_nxt = 1'b1;
          end else begin
            state_nxt = HDR1;
          end
        end
      end

      HDR1: begin
        if (in_hs) begin
          if (len_bad) begin
            // Pulse now; the DROP state must not pulse a second time.
            drop_nxt       = 1'b1;
            drop_armed_nxt = 1'b0;
            state_nxt      = axis_i_tlast ? HDR0 : DROP;
          end else if (axis_i_tlast) begin
            drop_nxt  = (hdr_udp_len != UDP_HDR_LEN);
            state_nxt = HDR0;
          end else begin
            load_len  = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        axis_i_tready = axis_o_tready;
        axis_o_tvalid = axis_i_tvalid;
        axis_o_tlast  = axis_i_tlast;
        if (axis_i_tvalid && axis_o_tready && axis_i_tlast) begin
          state_nxt = HDR0;
        end
      end

      DROP: begin
        if (in_hs && axis_i_tlast) begin
          drop_nxt  = drop_armed;
          state_nxt = HDR0;
        end
      end

      default: state_nxt = HDR0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state      <= HDR0;
      drop       <= 1'b0;
      drop_armed <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop       <= drop_nxt;
      drop_armed <= drop_armed_nxt;
    end
  end

  // Sideband registers change only on header handshakes, so they hold for
  // the whole payload of the frame.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      axis_o_src_port <= '0;
      axis_o_dst_port <= '0;
      axis_o_src_ip   <= '0;
      axis_o_dst_ip   <= '0;
      axis_o_length   <= '0;
    end else begin
      if (load_hdr0) begin
        axis_o_src_port <= hdr_src_port;
        axis_o_dst_port <= hdr_dst_port;
        axis_o_src_ip   <= axis_i_src_ip;
        axis_o_dst_ip   <= axis_i_dst_ip;
      end
      if (load_len) begin
        axis_o_length <= hdr_udp_len - UDP_HDR_LEN;
      end
    end
  end

endmodule

// File: tb/tb_udp_deframer.sv
// Scoreboard bench for udp_deframer: directed frames, expected payload beats
// and sidebands queued by the driver and compared by an independent monitor.
module tb_udp_deframer;

  logic        clk = 1'b0;
  logic        sresetn;
  logic [31:0] axis_i_tdata;
  logic        axis_i_tvalid;
  logic        axis_i_tlast;
  logic        axis_i_tready;
  logic [15:0] axis_i_length;
  logic [7:0]  axis_i_protocol;
  logic [31:0] axis_i_src_ip;
  logic [31:0] axis_i_dst_ip;
  logic [31:0] axis_o_tdata;
  logic        axis_o_tvalid;
  logic        axis_o_tlast;
  logic        axis_o_tready;
  logic [15:0] axis_o_length;
  logic [15:0] axis_o_src_port;
  logic [15:0] axis_o_dst_port;
  logic [31:0] axis_o_src_ip;
  logic [31:0] axis_o_dst_ip;
  logic        drop;

  udp_deframer #(.LISTEN_PORT(16'h0050)) dut (
    .clk             (clk),
    .sresetn         (sresetn),
    .axis_i_tdata    (axis_i_tdata),
    .axis_i_tvalid   (axis_i_tvalid),
    .axis_i_tlast    (axis_i_tlast),
    .axis_i_tready   (axis_i_tready),
    .axis_i_length   (axis_i_length),
    .axis_i_protocol (axis_i_protocol),
    .axis_i_src_ip   (axis_i_src_ip),
    .axis_i_dst_ip   (axis_i_dst_ip),
    .axis_o_tdata    (axis_o_tdata),
    .axis_o_tvalid   (axis_o_tvalid),
    .axis_o_tlast    (axis_o_tlast),
    .axis_o_tready   (axis_o_tready),
    .axis_o_length   (axis_o_length),
    .axis_o_src_port (axis_o_src_port),
    .axis_o_dst_port (axis_o_dst_port),
    .axis_o_src_ip   (axis_o_src_ip),
    .axis_o_dst_ip   (axis_o_dst_ip),
    .drop            (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] len;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [31:0] sip;
    logic [31:0] dip;
  } exp_t;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          drop_seen = 0;
  int          exp_drops = 0;
  bit          bp_en     = 1'b0;
  logic [31:0] beats [0:7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] data, input logic last, input logic [15:0] len,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [31:0] sip, input logic [31:0] dip);
    exp_t e;
    e.data = data; e.last = last; e.len = len; e.sp = sp; e.dp = dp; e.sip = sip; e.dip = dip;
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    int  cyc;
    bit  done;
    axis_i_tdata  = data;
    axis_i_tlast  = last;
    axis_i_tvalid = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      if (axis_i_tready) done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL input_handshake_timeout beat=%h got=no_ready expected=ready", data);
    end
  endtask

  task automatic run_frame(input int n, input logic [15:0] ip_len, input logic [7:0] proto,
                           input logic [31:0] sip, input logic [31:0] dip, input bit bp);
    axis_i_length   = ip_len;
    axis_i_protocol = proto;
    axis_i_src_ip   = sip;
    axis_i_dst_ip   = dip;
    bp_en           = bp;
    for (int i = 0; i < n; i++) send_beat(beats[i], (i == n - 1));
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    bp_en         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_count", drop_seen, exp_drops);
  endtask

  // Output backpressure, re-rolled every cycle while enabled.
  initial begin
    axis_o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis_o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every output handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sresetn === 1'b1) begin
        if (axis_o_tvalid && axis_o_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat got=%h expected=no_beat", axis_o_tdata);
          end else begin
            e = exp_q.pop_front();
            check("o_tdata",    axis_o_tdata,           e.data);
            check("o_tlast",    32'(axis_o_tlast),      32'(e.last));
            check("o_length",   32'(axis_o_length),     32'(e.len));
            check("o_src_port", 32'(axis_o_src_port),   32'(e.sp));
            check("o_dst_port", 32'(axis_o_dst_port),   32'(e.dp));
            check("o_src_ip",   axis_o_src_ip,          e.sip);
            check("o_dst_ip",   axis_o_dst_ip,          e.dip);
          end
        end
        if (drop) drop_seen++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cyc;
    sresetn         = 1'b0;
    axis_i_tdata    = '0;
    axis_i_tvalid   = 1'b0;
    axis_i_tlast    = 1'b0;
    axis_i_length   = '0;
    axis_i_protocol = '0;
    axis_i_src_ip   = '0;
    axis_i_dst_ip   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_tready",   32'(axis_i_tready),   32'h1);
    check("rst_o_tvalid",   32'(axis_o_tvalid),   32'h0);
    check("rst_drop",       32'(drop),            32'h0);
    check("rst_o_length",   32'(axis_o_length),   32'h0);
    check("rst_o_src_port", 32'(axis_o_src_port), 32'h0);
    check("rst_o_dst_port", 32'(axis_o_dst_port), 32'h0);
    check("rst_o_src_ip",   axis_o_src_ip,        32'h0);
    check("rst_o_dst_ip",   axis_o_dst_ip,        32'h0);
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // UDP 0x1234 -> 0x0050, udp_len 20, three payload words, backpressure.
    beats[0] = 32'h5000_3412; beats[1] = 32'hcdab_1400;
    beats[2] = 32'h1111_1111; beats[3] = 32'h2222_2222; beats[4] = 32'h3333_3333;
    expect_beat(32'h1111_1111, 1'b0, 16'd12, 16'h1234, 16'h0050, 32'h0a00_0001, 32'h0a00_0002);
    expect_beat(32'h2222_2222, 1'b0, 16'd12, 16'h1234, 16'h0050, 32'h0a00_0001, 32'h0a00_0002);
    expect_beat(32'h3333_3333, 1'b1, 16'd12, 16'h1234, 16'h0050, 32'h0a00_0001, 32'h0a00_0002);
    run_frame(5, 16'd20, 8'd17, 32'h0a00_0001, 32'h0a00_0002, 1'b1);

    // TCP frame, five beats: single drop at its last beat.
    beats[0] = 32'h5000_3412; beats[1] = 32'hcdab_1400;
    beats[2] = 32'haaaa_aaaa; beats[3] = 32'hbbbb_bbbb; beats[4] = 32'hcccc_cccc;
    exp_drops++;
    run_frame(5, 16'd20, 8'd6, 32'h0a00_0001, 32'h0a00_0002, 1'b0);

    // Next UDP frame passes: 0xabcd -> 0x0050, udp_len 12, one word.
    beats[0] = 32'h5000_cdab; beats[1] = 32'hcdab_0c00; beats[2] = 32'hdead_beef;
    expect_beat(32'hdead_beef, 1'b1, 16'd4, 16'habcd, 16'h0050, 32'hac10_0005, 32'hac10_0009);
    run_frame(3, 16'd12, 8'd17, 32'hac10_0005, 32'hac10_0009, 1'b0);

    // udp_len 4 (below header size).
    beats[0] = 32'h5000_3412; beats[1] = 32'hcdab_0400;
    beats[2] = 32'h0101_0101; beats[3] = 32'h0202_0202; beats[4] = 32'h0303_0303;
    exp_drops++;
    run_frame(5, 16'd20, 8'd17, 32'h0a00_0001, 32'h0a00_0002, 1'b0);

    // udp_len 40 exceeds IP length 20.
    beats[1] = 32'hcdab_2800;
    exp_drops++;
    run_frame(5, 16'd20, 8'd17, 32'h0a00_0001, 32'h0a00_0002, 1'b0);

    // Empty datagram: udp_len 8 ending on header beat 1.
    beats[0] = 32'h5000_3412; beats[1] = 32'hcdab_0800;
    run_frame(2, 16'd8, 8'd17, 32'h0a00_0001, 32'h0a00_0002, 1'b0);

    // udp_len 12 but frame ends on header beat 1.
    beats[1] = 32'hcdab_0c00;
    exp_drops++;
    run_frame(2, 16'd12, 8'd17, 32'h0a00_0001, 32'h0a00_0002, 1'b0);

    // Runt: tlast on header beat 0.
    beats[0] = 32'h5000_3412;
    exp_drops++;
    run_frame(1, 16'd20, 8'd17, 32'h0101_0101, 32'h0202_0202, 1'b0);

    // Valid frame after the runt: fresh sidebands 0x0400 -> 0x0050, udp_len 16.
    beats[0] = 32'h5000_0004; beats[1] = 32'hcdab_1000;
    beats[2] = 32'h0403_0201; beats[3] = 32'h0807_0605;
    expect_beat(32'h0403_0201, 1'b0, 16'd8, 16'h0400, 16'h0050, 32'hc0a8_0101, 32'hc0a8_01ff);
    expect_beat(32'h0807_0605, 1'b1, 16'd8, 16'h0400, 16'h0050, 32'hc0a8_0101, 32'hc0a8_01ff);
    run_frame(4, 16'd16, 8'd17, 32'hc0a8_0101, 32'hc0a8_01ff, 1'b1);

    // Destination 0x0051: rejected only when the port filter is compiled in.
    beats[0] = 32'h5100_3412; beats[1] = 32'hcdab_0c00; beats[2] = 32'hfeed_f00d;
`ifdef UDP_DEFRAMER_PORT_FILTER_EN
    exp_drops++;
`else
    expect_beat(32'hfeed_f00d, 1'b1, 16'd4, 16'h1234, 16'h0051, 32'h0a00_0003, 32'h0a00_0004);
`endif
    run_frame(3, 16'd12, 8'd17, 32'h0a00_0003, 32'h0a00_0004, 1'b0);

    // Destination 0x0050 passes in either build.
    beats[0] = 32'h5000_3412; beats[2] = 32'hc0de_cafe;
    expect_beat(32'hc0de_cafe, 1'b1, 16'd4, 16'h1234, 16'h0050, 32'h0a00_0003, 32'h0a00_0004);
    run_frame(3, 16'd12, 8'd17, 32'h0a00_0003, 32'h0a00_0004, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
